// File: rtl/decoder38_seq.sv
// decoder38_seq: sequenced 3-to-8 decoder.
// Codes arrive over a valid/ready handshake, queue in a small FIFO, and are
// driven one at a time as a one-hot byte on oData for DWELL enabled cycles.
// iEna low pauses the dwell counter and blanks the outputs; the FIFO keeps
// accepting pushes while paused.
// Optional build macro DECODER38_ACTIVE_LOW_OUT_EN: oData is inverted
// (74x138-style active-low, blank value 8'hFF). Undefined: active-high.
module decoder38_seq #(
  parameter int unsigned DWELL      = 4,  // cycles per code, 1..255
  parameter int unsigned FIFO_DEPTH = 4   // power of two, 2..16
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic [2:0] iData,
  input  logic       iValid,
  output logic       oReady,
  input  logic       iEna,
  output logic [7:0] oData,
  output logic       oValid,
  output logic       oBusy
);

  localparam int unsigned CNT_W   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned COUNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DWELL - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(FIFO_DEPTH);

  typedef enum logic {
    IDLE,
    SHOW
  } state_t;

  // ---------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // ---------------------------------------------------------------------
  logic [2:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [COUNT_W-1:0] count;
  logic               ready_q;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [2:0]         head;

  // ---------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------
  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [7:0]         onehot_q;
  logic               dwell_done;
  logic [7:0]         shown;

  assign full  = (count == COUNT_MAX);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // ready_q keeps oReady low through reset and up to the first edge after
  // release; afterwards readiness depends only on the FIFO fill level.
  assign oReady = ready_q && !full;
  assign push   = iValid && oReady;

  assign dwell_done = (cnt == CNT_LAST);

  // Decide whether the head code is consumed at the coming edge.
  always_comb begin
    pop = 1'b0;
    if (iEna && !empty) begin
      case (state)
        IDLE:    pop = 1'b1;
        SHOW:    pop = dwell_done;
        default: pop = 1'b0;
      endcase
    end
  end

  // Arm oReady on the first clock edge after reset release.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end

  // FIFO data array; contents need no reset because count gates every read.
  always_ff @(posedge iClk) begin
    if (push) begin
      mem[wr_ptr] <= iData;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + COUNT_W'(1);
        2'b01:   count <= count - COUNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sequencer: load codes from the FIFO and time each dwell; frozen while iEna is low.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      onehot_q <= '0;
    end else if (iEna) begin
      case (state)
        IDLE: begin
          if (pop) begin
            state    <= SHOW;
            cnt      <= '0;
            onehot_q <= 8'b1 << head;
          end
        end
        SHOW: begin
          if (dwell_done) begin
            if (pop) begin
              cnt      <= '0;
              onehot_q <= 8'b1 << head;
            end else begin
              state    <= IDLE;
              cnt      <= '0;
              onehot_q <= '0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          onehot_q <= '0;
        end
      endcase
    end
  end

  // Blanking by iEna is applied after the register so a pause takes effect
  // in the same cycle and the held code reappears unchanged on resume.
  assign shown  = iEna ? onehot_q : '0;
  assign oValid = iEna && (state == SHOW);
  assign oBusy  = (state == SHOW) || !empty;

`ifdef DECODER38_ACTIVE_LOW_OUT_EN
  assign oData = ~shown;
`else
  assign oData = shown;
`endif

endmodule

// File: tb/tb_decoder38_seq.sv
// Self-checking bench for decoder38_seq: a DWELL=4 instance checked against
// a queue-based reference model plus directed expectations, and a DWELL=1
// instance for single-cycle streaming.
module tb_decoder38_seq;

  localparam int DW    = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;

  logic [2:0] data  = '0;
  logic       valid = 1'b0;
  logic       ena   = 1'b1;
  logic       ready;
  logic [7:0] odata;
  logic       ovalid;
  logic       busy;

  logic [2:0] data1  = '0;
  logic       valid1 = 1'b0;
  logic       ena1   = 1'b1;
  logic       ready1;
  logic [7:0] odata1;
  logic       ovalid1;
  logic       busy1;

  decoder38_seq #(.DWELL(DW), .FIFO_DEPTH(DEPTH)) dut (
    .iClk(clk), .iRst_n(rst_n), .iData(data), .iValid(valid), .oReady(ready),
    .iEna(ena), .oData(odata), .oValid(ovalid), .oBusy(busy)
  );

  decoder38_seq #(.DWELL(1), .FIFO_DEPTH(4)) dut1 (
    .iClk(clk), .iRst_n(rst_n), .iData(data1), .iValid(valid1), .oReady(ready1),
    .iEna(ena1), .oData(odata1), .oValid(ovalid1), .oBusy(busy1)
  );

  int checks = 0;
  int passes = 0;

  function automatic logic [7:0] pol(input logic [7:0] v);
`ifdef DECODER38_ACTIVE_LOW_OUT_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  // Reference model for the DWELL=4 instance: a queue of pending codes, the
  // code on display (-1 when none) and the number of enabled cycles it still
  // has to remain visible.
  int mq[$];
  int m_cur  = -1;
  int m_left = 0;
  bit m_rdy  = 1'b0;
  bit m_push;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_cur  = -1;
      m_left = 0;
      m_rdy  = 1'b0;
    end else begin
      m_push = valid && m_rdy && (mq.size() < DEPTH);
      if (ena) begin
        if (m_cur >= 0) begin
          m_left = m_left - 1;
          if (m_left == 0) m_cur = -1;
        end
        if (m_cur < 0 && mq.size() > 0) begin
          m_cur  = mq.pop_front();
          m_left = DW;
        end
      end
      if (m_push) mq.push_back(int'(data));
      m_rdy = 1'b1;
    end
  end

  // Expected {oData, oValid, oReady, oBusy} for the DWELL=4 instance.
  function automatic logic [10:0] model_out();
    logic [7:0] oh;
    logic       on;
    on = (m_cur >= 0) && ena;
    oh = on ? (8'd1 << m_cur) : 8'd0;
    return {pol(oh), on, m_rdy && (mq.size() < DEPTH), (m_cur >= 0) || (mq.size() > 0)};
  endfunction

  task automatic tick(input logic v, input logic [2:0] d, input logic e);
    @(negedge clk);
    valid = v; data = d; ena = e;
    @(posedge clk);
    #1;
  endtask

  task automatic tick1(input logic v, input logic [2:0] d);
    @(negedge clk);
    valid1 = v; data1 = d; ena1 = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [10:0] exp;
    repeat (2) @(negedge clk);
    exp = {pol(8'h00), 1'b0, 1'b0, 1'b0};
    checks++;
    if ({odata, ovalid, ready, busy} !== exp)
      $display("FAIL reset_hold: got %h want %h", {odata, ovalid, ready, busy}, exp);
    else passes++;
    checks++;
    if ({odata1, ovalid1, ready1, busy1} !== exp)
      $display("FAIL reset_hold_d1: got %h want %h", {odata1, ovalid1, ready1, busy1}, exp);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp = {pol(8'h00), 1'b0, 1'b1, 1'b0};
    checks++;
    if ({odata, ovalid, ready, busy} !== exp)
      $display("FAIL reset_release: got %h want %h", {odata, ovalid, ready, busy}, exp);
    else passes++;
  endtask

  task automatic test_single();
    logic [10:0] exp;
    tick(1'b1, 3'd3, 1'b1);
    for (int c = 0; c <= 7; c++) begin
      if (c > 0) tick(1'b0, 3'd0, 1'b1);
      exp = {pol((c >= 1 && c <= 4) ? 8'h08 : 8'h00), (c >= 1 && c <= 4), 1'b1, (c <= 4)};
      checks++;
      if ({odata, ovalid, ready, busy} !== exp)
        $display("FAIL single cyc%0d: got %h want %h", c, {odata, ovalid, ready, busy}, exp);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] exp;
    logic [7:0]  oh;
    logic [2:0]  codes [3];
    codes[0] = 3'd0; codes[1] = 3'd7; codes[2] = 3'd5;
    for (int c = 0; c <= 15; c++) begin
      if (c < 3) tick(1'b1, codes[c], 1'b1);
      else       tick(1'b0, 3'd0, 1'b1);
      if (c >= 1 && c <= 12) oh = 8'd1 << codes[(c - 1) / 4];
      else                   oh = 8'h00;
      exp = {pol(oh), (c >= 1 && c <= 12), 1'b1, (c <= 12)};
      checks++;
      if ({odata, ovalid, ready, busy} !== exp)
        $display("FAIL back_to_back cyc%0d: got %h want %h", c, {odata, ovalid, ready, busy}, exp);
      else passes++;
    end
  endtask

  task automatic test_backpressure();
    int          idx;
    bit          acc;
    bit          stalled;
    int          prev;
    int          code;
    int          got[$];
    bit          bad;
    logic [7:0]  raw;
    logic [10:0] exp;
    idx = 0; stalled = 1'b0; prev = -1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      valid = (idx < 6); data = 3'(idx + 1); ena = 1'b1;
      acc = valid && m_rdy && (mq.size() < DEPTH);
      @(posedge clk);
      #1;
      if (acc) idx++;
      exp = model_out();
      checks++;
      if ({odata, ovalid, ready, busy} !== exp)
        $display("FAIL backpressure cyc%0d: got %h want %h", c, {odata, ovalid, ready, busy}, exp);
      else passes++;
      if (!ready) stalled = 1'b1;
      raw = pol(odata);
      code = -1;
      for (int b = 0; b < 8; b++) if (raw[b]) code = b;
      if (ovalid && code != prev) got.push_back(code);
      prev = ovalid ? code : -1;
      if (idx == 6 && m_cur < 0 && mq.size() == 0) break;
    end
    valid = 1'b0;
    checks++;
    if (!(idx == 6 && m_cur < 0 && mq.size() == 0))
      $display("FAIL backpressure_done: accepted %0d want 6 within budget", idx);
    else passes++;
    checks++;
    if (stalled !== 1'b1) $display("FAIL backpressure_stall: oReady low seen %0d want 1", stalled);
    else passes++;
    bad = (got.size() != 6);
    for (int i = 0; i < got.size() && i < 6; i++) if (got[i] != i + 1) bad = 1'b1;
    checks++;
    if (bad) $display("FAIL backpressure_order: got %0d codes %p want 1..6", got.size(), got);
    else passes++;
  endtask

  task automatic test_pause();
    logic [10:0] exp;
    bit          on;
    bit          e;
    for (int c = 0; c <= 9; c++) begin
      e = !(c >= 3 && c <= 5);
      tick(c == 0, 3'd2, e);
      on = (c == 1 || c == 2 || c == 6 || c == 7);
      exp = {pol(on ? 8'h04 : 8'h00), on, 1'b1, (c <= 7)};
      checks++;
      if ({odata, ovalid, ready, busy} !== exp)
        $display("FAIL pause cyc%0d: got %h want %h", c, {odata, ovalid, ready, busy}, exp);
      else passes++;
      checks++;
      if ({odata, ovalid, ready, busy} !== model_out())
        $display("FAIL pause_model cyc%0d: got %h want %h", c, {odata, ovalid, ready, busy}, model_out());
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] exp;
    for (int c = 0; c < 3; c++) tick(1'b1, 3'(c + 1), 1'b1);
    tick(1'b0, 3'd0, 1'b1);
    checks++;
    if ({odata, ovalid, busy} !== {pol(8'h02), 1'b1, 1'b1} || mq.size() != 2)
      $display("FAIL reset_mid_pre: got %h want %h q=%0d", {odata, ovalid, busy}, {pol(8'h02), 2'b11}, mq.size());
    else passes++;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp = {pol(8'h00), 1'b0, 1'b0, 1'b0};
    checks++;
    if ({odata, ovalid, ready, busy} !== exp)
      $display("FAIL reset_mid_async: got %h want %h", {odata, ovalid, ready, busy}, exp);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick(1'b0, 3'd0, 1'b1);
      exp = {pol(8'h00), 1'b0, 1'b1, 1'b0};
      checks++;
      if ({odata, ovalid, ready, busy} !== exp)
        $display("FAIL reset_mid_after cyc%0d: got %h want %h", c, {odata, ovalid, ready, busy}, exp);
      else passes++;
    end
  endtask

  task automatic test_random();
    logic [10:0] exp;
    for (int c = 0; c < 400; c++) begin
      tick(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ($urandom_range(0, 9) != 0));
      exp = model_out();
      checks++;
      if ({odata, ovalid, ready, busy} !== exp)
        $display("FAIL random cyc%0d: got %h want %h", c, {odata, ovalid, ready, busy}, exp);
      else passes++;
    end
    for (int c = 0; c < 40; c++) tick(1'b0, 3'd0, 1'b1);
    checks++;
    if ({odata, ovalid, ready, busy} !== {pol(8'h00), 3'b010})
      $display("FAIL random_drain: got %h want %h", {odata, ovalid, ready, busy}, {pol(8'h00), 3'b010});
    else passes++;
  endtask

  task automatic test_dwell1();
    logic [10:0] exp;
    logic [7:0]  oh;
    logic [2:0]  codes [5];
    codes[0] = 3'd4; codes[1] = 3'd6; codes[2] = 3'd1; codes[3] = 3'd7; codes[4] = 3'd0;
    for (int c = 0; c <= 7; c++) begin
      tick1(c < 5, (c < 5) ? codes[c] : 3'd0);
      oh = (c >= 1 && c <= 5) ? (8'd1 << codes[c - 1]) : 8'h00;
      exp = {pol(oh), (c >= 1 && c <= 5), 1'b1, (c <= 5)};
      checks++;
      if ({odata1, ovalid1, ready1, busy1} !== exp)
        $display("FAIL dwell1 cyc%0d: got %h want %h", c, {odata1, ovalid1, ready1, busy1}, exp);
      else passes++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    repeat (3) tick(1'b0, 3'd0, 1'b1);
    test_backpressure();
    test_pause();
    test_reset_mid();
    test_random();
    test_dwell1();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
